traffic_light_controller: RTL and testbench
===========================================

// Module: traffic_light_controller
// PURPOSE
//  Highway/country-road light sequencer; the consumer of the traffic timer's time_country/time_yellow flags.
//  Drives the timer's state input and issues a synchronous timer_restart pulse on every state change.
//  Conditions the raw car sensor into car_sync for its own use and for the timer.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable cycles before car_sync changes (CAR_DEBOUNCE_EN only; 20 ms @ 50 MHz)
// PORTS
//  clock          in   1  system clock, 50 MHz
//  reset          in   1  synchronous, active-high
//  car_raw        in   1  asynchronous country-road car sensor
//  time_country   in   1  timer flag: long interval elapsed
//  time_yellow    in   1  timer flag: yellow interval elapsed
//  state          out  2  HG=00 HY=01 SG=11 SY=10 (Gray sequence), registered
//  highway_light  out  3  {red,yellow,green}, one-hot, registered
//  country_light  out  3  {red,yellow,green}, one-hot, registered
//  car_sync       out  1  synchronized (optionally debounced) car request
//  timer_restart  out  1  one-cycle pulse: timer must clear its count
// BEHAVIOUR
//  Reset (sync): state=HG, highway=001, country=100, car_sync=0, timer_restart=0, sync/debounce regs cleared.
//  First clock edge with reset low: timer_restart=1 for exactly one cycle (fresh timer start).
//  Transitions (evaluated each clock edge, not in blanking cycle):
//   HG->HY  car_sync & time_country
//   HY->SG  time_yellow
//   SG->SY  ~car_sync | time_country
//   SY->HG  time_yellow
//  Otherwise state holds. No transition ever skips a state.
//  On each transition: state, lights and timer_restart=1 all update on the same edge; pulse lasts 1 cycle.
//  Blanking: cycle in which timer_restart=1 ignores time_country/time_yellow (stale flags);
//   earliest next transition is the 2nd edge after entry.
//  Lights: HG hwy=001 cty=100; HY hwy=010 cty=100; SG hwy=100 cty=001; SY hwy=100 cty=010.
//   Never both roads non-red; outputs a pure function of registered state (no glitches).
//  car_raw: 2-flop synchronizer; car_sync latency 2 edges from car_raw change (without debounce).
//  Simultaneous car_sync fall and time_country in SG: single transition to SY.
//  Reset mid-operation: next edge forces HG/reset values regardless of state or pending pulse.
// CONFIGURATION
//  CAR_DEBOUNCE_EN defined: car_sync follows synchronized input only after it differs from car_sync
//   for DEBOUNCE_CYCLES consecutive cycles; counter width $clog2(DEBOUNCE_CYCLES+1), clears on any bounce.
//   Latency = 2 + DEBOUNCE_CYCLES edges.
//  CAR_DEBOUNCE_EN undefined: car_sync = 2nd synchronizer flop; no counter logic instantiated.
// STRUCTURE
//  Package traffic_pkg: state encodings (HG/HY/SG/SY), light encodings (RED=100, YELLOW=010, GREEN=001).
//  Sub-module car_sensor_sync: synchronizer + optional debounce, ports clock, reset, car_raw, car_sync.
//  Top: state register, next-state logic, blanking flag, light decode.
// TESTING (DEBOUNCE_CYCLES=4 in simulation)
//  Reset 3 cycles -> state=00, hwy=001, cty=100, car_sync=0; after release timer_restart high exactly 1 cycle.
//  HG, time_country=1, car_raw=0 for 20 cycles -> state stays 00, no timer_restart pulse.
//  Full loop: car_raw=1,time_country=1 -> 01 (+pulse); time_yellow=1 -> 11; car_raw=0 -> 10; time_yellow=1 -> 00.
//  Enter HY with time_yellow already 1 -> SG on 2nd edge after entry, never 1st; exactly one pulse per change.
//  car_raw 3-cycle glitch -> car_sync stays 0 (EN); undefined EN -> car_sync=1 two edges after rise.
//  Reset asserted in SG -> next edge state=00, hwy=001, cty=100, timer_restart=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state and light encodings shared by the traffic light controller
package traffic_pkg;

  // Gray sequence: every legal transition flips exactly one state bit.
  typedef enum logic [1:0] {
    HG = 2'b00,
    HY = 2'b01,
    SG = 2'b11,
    SY = 2'b10
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef struct packed {
    logic [2:0] highway;
    logic [2:0] country;
  } lights_t;

  function automatic lights_t decode_lights(input state_t s);
    lights_t l;
    case (s)
      HG:      l = '{highway: GREEN,  country: RED};
      HY:      l = '{highway: YELLOW, country: RED};
      SG:      l = '{highway: RED,    country: GREEN};
      SY:      l = '{highway: RED,    country: YELLOW};
      default: l = '{highway: RED,    country: RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/car_sensor_sync.sv
// rtl/car_sensor_sync.sv - 2-flop car sensor synchronizer, debounced when CAR_DEBOUNCE_EN is defined
module car_sensor_sync #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic car_raw,
  output logic car_sync
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = car_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef CAR_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          car_q, car_d;

  // Output only follows after the new level has held for the full window; any bounce restarts it.
  always_comb begin
    cnt_d = '0;
    car_d = car_q;
    if (sync2_q != car_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        car_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      car_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      car_q <= car_d;
    end
  end

  assign car_sync = car_q;
`else
  assign car_sync = sync2_q;
`endif

endmodule

// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - highway/country light sequencer with timer restart pulse
// Optional car sensor debounce selected by CAR_DEBOUNCE_EN.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       car_raw,
  input  logic       time_country,
  input  logic       time_yellow,
  output logic [1:0] state,
  output logic [2:0] highway_light,
  output logic [2:0] country_light,
  output logic       car_sync,
  output logic       timer_restart
);

  state_t  state_q, state_d;
  lights_t lights_q, lights_d;
  logic    restart_q, restart_d;
  logic    started_q, started_d;

  car_sensor_sync #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_car_sensor_sync (
    .clock   (clock),
    .reset   (reset),
    .car_raw (car_raw),
    .car_sync(car_sync)
  );

  // Timer flags are stale while the restart pulse is out, so no move is taken in that cycle.
  always_comb begin
    state_d   = state_q;
    started_d = 1'b1;
    if (started_q && !restart_q) begin
      case (state_q)
        HG:      if (car_sync && time_country)  state_d = HY;
        HY:      if (time_yellow)               state_d = SG;
        SG:      if (!car_sync || time_country) state_d = SY;
        SY:      if (time_yellow)               state_d = HG;
        default:                                state_d = HG;
      endcase
    end
    restart_d = !started_q || (state_d != state_q);
    lights_d  = decode_lights(state_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= HG;
      lights_q  <= '{highway: GREEN, country: RED};
      restart_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lights_q  <= lights_d;
      restart_q <= restart_d;
      started_q <= started_d;
    end
  end

  assign state         = state_q;
  assign highway_light = lights_q.highway;
  assign country_light = lights_q.country;
  assign timer_restart = restart_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - scoreboard bench for traffic_light_controller
module tb_traffic_light_controller;

  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       car_raw = 1'b0;
  logic       time_country = 1'b0;
  logic       time_yellow = 1'b0;
  logic [1:0] state;
  logic [2:0] highway_light;
  logic [2:0] country_light;
  logic       car_sync;
  logic       timer_restart;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] st;
    logic [2:0] hwy;
    logic [2:0] cty;
  } exp_t;

  exp_t exp_q[$];

  traffic_light_controller #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock        (clock),
    .reset        (reset),
    .car_raw      (car_raw),
    .time_country (time_country),
    .time_yellow  (time_yellow),
    .state        (state),
    .highway_light(highway_light),
    .country_light(country_light),
    .car_sync     (car_sync),
    .timer_restart(timer_restart)
  );

  always #5 clock = ~clock;

  function automatic exp_t expect_for(input logic [1:0] st);
    exp_t e;
    case (st)
      2'b00:   e = '{st: 2'b00, hwy: 3'b001, cty: 3'b100};
      2'b01:   e = '{st: 2'b01, hwy: 3'b010, cty: 3'b100};
      2'b11:   e = '{st: 2'b11, hwy: 3'b100, cty: 3'b001};
      default: e = '{st: 2'b10, hwy: 3'b100, cty: 3'b010};
    endcase
    return e;
  endfunction

  task automatic push_exp(input logic [1:0] st);
    exp_q.push_back(expect_for(st));
  endtask

  task automatic wait_restart(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clock);
      if (timer_restart === 1'b1) got = 1'b1;
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      checks++;
      if (highway_light !== 3'b100 && country_light !== 3'b100) begin
        failures++;
        $display("FAIL both_non_red hwy=%b cty=%b", highway_light, country_light);
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b want=00", state); end
    checks++; if (highway_light !== 3'b001) begin failures++; $display("FAIL reset_hwy got=%b want=001", highway_light); end
    checks++; if (country_light !== 3'b100) begin failures++; $display("FAIL reset_cty got=%b want=100", country_light); end
    checks++; if (car_sync !== 1'b0) begin failures++; $display("FAIL reset_car_sync got=%b want=0", car_sync); end
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL reset_restart got=%b want=0", timer_restart); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (timer_restart !== 1'b1) begin failures++; $display("FAIL first_restart got=%b want=1", timer_restart); end
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL first_state got=%b want=00", state); end
    @(negedge clock);
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL first_restart_width got=%b want=0", timer_restart); end
  endtask

  task automatic test_hg_hold;
    time_country = 1'b1;
    car_raw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++; if (state !== 2'b00) begin failures++; $display("FAIL hold_state cyc=%0d got=%b want=00", i, state); end
      checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL hold_restart cyc=%0d got=%b want=0", i, timer_restart); end
    end
  endtask

  task automatic test_full_loop;
    bit   got;
    exp_t e;
    car_raw = 1'b1; time_country = 1'b1; push_exp(2'b01);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL loop_hy_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL loop_hy got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    @(negedge clock);
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL loop_hy_width got=%b want=0", timer_restart); end

    time_country = 1'b0; time_yellow = 1'b1; push_exp(2'b11);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL loop_sg_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL loop_sg got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    @(negedge clock);
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL loop_sg_width got=%b want=0", timer_restart); end

    time_yellow = 1'b0; car_raw = 1'b0; push_exp(2'b10);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL loop_sy_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL loop_sy got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    @(negedge clock);
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL loop_sy_width got=%b want=0", timer_restart); end

    time_yellow = 1'b1; push_exp(2'b00);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL loop_hg_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL loop_hg got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    time_yellow = 1'b0;
    @(negedge clock);
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL loop_hg_width got=%b want=0", timer_restart); end
  endtask

  task automatic test_yellow_blanking;
    bit   got;
    exp_t e;
    time_yellow = 1'b1; car_raw = 1'b1; time_country = 1'b1; push_exp(2'b01);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL blank_hy_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL blank_hy got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    time_country = 1'b0; push_exp(2'b11);
    @(negedge clock);
    checks++; if (state !== 2'b01) begin failures++; $display("FAIL blank_first_edge_state got=%b want=01", state); end
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL blank_first_edge_restart got=%b want=0", timer_restart); end
    @(negedge clock);
    e = exp_q.pop_front();
    checks++; if (timer_restart !== 1'b1) begin failures++; $display("FAIL blank_second_edge_restart got=%b want=1", timer_restart); end
    checks++; if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL blank_sg got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end

    time_yellow = 1'b0; car_raw = 1'b0; time_country = 1'b1; push_exp(2'b10);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL simul_sy_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL simul_sy got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++; if (state !== 2'b10 || timer_restart !== 1'b0) begin failures++; $display("FAIL simul_sy_hold cyc=%0d got=%b/%b want=10/0", i, state, timer_restart); end
    end

    time_country = 1'b0; time_yellow = 1'b1; push_exp(2'b00);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL blank_hg_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL blank_hg got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    time_yellow = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_glitch;
    logic seen [12];
    time_country = 1'b0; time_yellow = 1'b0;
    repeat (10) @(negedge clock);
    car_raw = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      seen[i] = car_sync;
      if (i == 2) car_raw = 1'b0;
    end
`ifdef CAR_DEBOUNCE_EN
    for (int i = 0; i < 12; i++) begin
      checks++; if (seen[i] !== 1'b0) begin failures++; $display("FAIL glitch_debounced edge=%0d got=%b want=0", i + 1, seen[i]); end
    end
`else
    checks++; if (seen[0] !== 1'b0) begin failures++; $display("FAIL glitch_edge1 got=%b want=0", seen[0]); end
    checks++; if (seen[1] !== 1'b1) begin failures++; $display("FAIL glitch_edge2 got=%b want=1", seen[1]); end
    checks++; if (seen[11] !== 1'b0) begin failures++; $display("FAIL glitch_settle got=%b want=0", seen[11]); end
`endif
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL glitch_state got=%b want=00", state); end
  endtask

  task automatic test_reset_in_sg;
    bit   got;
    exp_t e;
    car_raw = 1'b1; time_country = 1'b1; push_exp(2'b01);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL rst_hy_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL rst_hy got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    time_country = 1'b0; time_yellow = 1'b1; push_exp(2'b11);
    wait_restart(40, got); e = exp_q.pop_front();
    checks++; if (!got) begin failures++; $display("FAIL rst_sg_pulse got=0 want=1"); end
    else if ({state, highway_light, country_light} !== {e.st, e.hwy, e.cty}) begin failures++; $display("FAIL rst_sg got=%b/%b/%b want=%b/%b/%b", state, highway_light, country_light, e.st, e.hwy, e.cty); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (state !== 2'b00) begin failures++; $display("FAIL rst_mid_state got=%b want=00", state); end
    checks++; if (highway_light !== 3'b001) begin failures++; $display("FAIL rst_mid_hwy got=%b want=001", highway_light); end
    checks++; if (country_light !== 3'b100) begin failures++; $display("FAIL rst_mid_cty got=%b want=100", country_light); end
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL rst_mid_restart got=%b want=0", timer_restart); end
    checks++; if (car_sync !== 1'b0) begin failures++; $display("FAIL rst_mid_car_sync got=%b want=0", car_sync); end
    car_raw = 1'b0; time_yellow = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++; if (timer_restart !== 1'b1) begin failures++; $display("FAIL rst_mid_restart_after got=%b want=1", timer_restart); end
    @(negedge clock);
    checks++; if (timer_restart !== 1'b0) begin failures++; $display("FAIL rst_mid_restart_width got=%b want=0", timer_restart); end
  endtask

  initial begin
    test_reset();
    test_hg_hold();
    test_full_loop();
    test_yellow_blanking();
    test_glitch();
    test_reset_in_sg();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
